// File: rtl/parallel_gpio_pkg.sv
// Shared definitions for the parallel_gpio port: register offsets, index type
// and the byte-enable expansion helper.
package parallel_gpio_pkg;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t REG_OUT      = 3'd0;
  localparam reg_idx_t REG_SET      = 3'd1;
  localparam reg_idx_t REG_CLR      = 3'd2;
  localparam reg_idx_t REG_TGL      = 3'd3;
  localparam reg_idx_t REG_DIR      = 3'd4;
  localparam reg_idx_t REG_IN       = 3'd5;
  localparam reg_idx_t REG_EDGE     = 3'd6;
  localparam reg_idx_t REG_IRQ_MASK = 3'd7;

  // Each wmask bit qualifies one byte lane of the 32-bit data word.
  function automatic logic [31:0] wmask_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/parallel_gpio_if.sv
// Simple load/store bus between the CPU (master) and the GPIO port (slave).
interface parallel_gpio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ready;
  logic        active;

  modport master (
    output addr, wdata, wmask, wen, ren,
    input  rdata, ready, active
  );

  modport slave (
    input  addr, wdata, wmask, wen, ren,
    output rdata, ready, active
  );
endinterface

// File: rtl/parallel_gpio_sync.sv
// gpio_sync: WIDTH-wide two-flop synchroniser bringing asynchronous pad
// inputs into the clk domain.
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;

  // Two back-to-back flops to settle metastability on each pad bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= {WIDTH{1'b0}};
      s2_r <= {WIDTH{1'b0}};
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/parallel_gpio.sv
// Memory-mapped GPIO port: per-pin direction, atomic set/clear/toggle, synchronised
// input view. Rising-edge capture and irq exist only when PARALLEL_GPIO_IRQ_EN is defined.
module parallel_gpio
  import parallel_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hf000,
  parameter int          WIDTH     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  parallel_gpio_if.slave    bus,
  input  logic [WIDTH-1:0]  pins_in,
  output logic [WIDTH-1:0]  pins_out,
  output logic [WIDTH-1:0]  pins_oe,
  output logic              irq
);

  reg_idx_t         idx_s;
  logic             acc_s;
  logic             wr_s;
  logic [31:0]      bm_s;
  logic [31:0]      wd_s;
  logic [WIDTH-1:0] bmw_s;
  logic [WIDTH-1:0] wdw_s;
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] edge_rd_s;
  logic [WIDTH-1:0] irqm_rd_s;
  logic [31:0]      rd_s;
  logic             unused_bits_s;

  assign bus.active = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign acc_s      = (bus.wen | bus.ren) & bus.active;
  assign wr_s       = bus.wen & bus.active;
  assign idx_s      = bus.addr[4:2];
  assign bm_s       = wmask_bits(bus.wmask);
  assign wd_s       = bus.wdata & bm_s;
  // Bits at or above WIDTH are simply dropped, so they ignore writes.
  assign bmw_s      = bm_s[WIDTH-1:0];
  assign wdw_s      = wd_s[WIDTH-1:0];
  assign unused_bits_s = ^{bus.addr[1:0], wd_s, bm_s};

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pins_in),
    .q     (in_s)
  );

  // Read-back multiplexer; narrow registers are zero-extended to 32 bits.
  always_comb begin
    rd_s = 32'h0;
    case (idx_s)
      REG_OUT, REG_SET, REG_CLR, REG_TGL: rd_s = 32'(out_r);
      REG_DIR:      rd_s = 32'(dir_r);
      REG_IN:       rd_s = 32'(in_s);
      REG_EDGE:     rd_s = 32'(edge_rd_s);
      REG_IRQ_MASK: rd_s = 32'(irqm_rd_s);
      default:      rd_s = 32'h0;
    endcase
  end

  // Output latch and direction register, including the atomic bit operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= {WIDTH{1'b0}};
      dir_r <= {WIDTH{1'b0}};
    end else if (wr_s) begin
      case (idx_s)
        REG_OUT: out_r <= (out_r & ~bmw_s) | wdw_s;
        REG_SET: out_r <= out_r | wdw_s;
        REG_CLR: out_r <= out_r & ~wdw_s;
        REG_TGL: out_r <= out_r ^ wdw_s;
        REG_DIR: dir_r <= (dir_r & ~bmw_s) | wdw_s;
        default: begin
          out_r <= out_r;
          dir_r <= dir_r;
        end
      endcase
    end
  end

  assign pins_out = out_r;
  assign pins_oe  = dir_r;

  // Bus response: rdata captures the pre-write value of the addressed register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata <= 32'h0;
      bus.ready <= 1'b0;
    end else begin
      bus.ready <= acc_s;
      if (acc_s) begin
        bus.rdata <= rd_s;
      end
    end
  end

`ifdef PARALLEL_GPIO_IRQ_EN
  logic [WIDTH-1:0] dly_r;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] irqm_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] clr_s;

  assign rise_s = in_s & ~dly_r;
  assign clr_s  = (wr_s && (idx_s == REG_EDGE)) ? wdw_s : {WIDTH{1'b0}};

  // Edge capture with write-1-to-clear; a new edge in the clear cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_r  <= {WIDTH{1'b0}};
      edge_r <= {WIDTH{1'b0}};
      irqm_r <= {WIDTH{1'b0}};
      irq    <= 1'b0;
    end else begin
      dly_r  <= in_s;
      edge_r <= (edge_r & ~clr_s) | rise_s;
      if (wr_s && (idx_s == REG_IRQ_MASK)) begin
        irqm_r <= (irqm_r & ~bmw_s) | wdw_s;
      end
      irq    <= |(edge_r & irqm_r);
    end
  end

  assign edge_rd_s = edge_r;
  assign irqm_rd_s = irqm_r;
`else
  assign edge_rd_s = {WIDTH{1'b0}};
  assign irqm_rd_s = {WIDTH{1'b0}};
  assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_gpio.sv
// Randomised scoreboard bench for parallel_gpio: a 32-pin and an 8-pin instance
// share one bus stimulus and are checked against a register-level reference model.
module tb_parallel_gpio;

  localparam logic [31:0] BASE = 32'hf000;
`ifdef PARALLEL_GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pins;
  logic [31:0] po32, oe32;
  logic [7:0]  po8, oe8;
  logic        irq32, irq8;

  always #5 clk = ~clk;

  parallel_gpio_if bus32 ();
  parallel_gpio_if bus8 ();

  parallel_gpio #(.BASE_ADDR(BASE), .WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32),
    .pins_in(pins), .pins_out(po32), .pins_oe(oe32), .irq(irq32)
  );

  parallel_gpio #(.BASE_ADDR(BASE), .WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8),
    .pins_in(pins[7:0]), .pins_out(po8), .pins_oe(oe8), .irq(irq8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] wm [2] = '{32'hffff_ffff, 32'h0000_00ff};
  logic [31:0] m_out [2];
  logic [31:0] m_dir [2];
  logic [31:0] m_edge [2];
  logic [31:0] m_imask [2];
  logic        m_irq [2];
  logic [31:0] h1, h2, h3;   // pins seen at the last three clock edges
  logic [32:0] q32 [$];
  logic [32:0] q8 [$];

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd32);
  endfunction

  function automatic logic [31:0] bytes_to_bits(input logic [3:0] m);
    logic [31:0] b = 32'h0;
    for (int i = 0; i < 4; i++)
      if (m[i]) b = b | (32'hff << (8 * i));
    return b;
  endfunction

  function automatic logic [31:0] model_read(input int d, input int off);
    case (off)
      0, 1, 2, 3: return m_out[d];
      4:          return m_dir[d];
      5:          return h2 & wm[d];
      6:          return IRQ_ON ? m_edge[d] : 32'h0;
      7:          return IRQ_ON ? m_imask[d] : 32'h0;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = 32'h0; m_dir[d] = 32'h0; m_edge[d] = 32'h0;
      m_imask[d] = 32'h0; m_irq[d] = 1'b0;
    end
    h1 = 32'h0; h2 = 32'h0; h3 = 32'h0;
    q32.delete();
    q8.delete();
  endtask

  task automatic step_model();
    bit          acc;
    int          off;
    logic [31:0] bits, v, rise, clr, rv;
    bit          nirq;
    acc  = (bus32.wen || bus32.ren) && in_window(bus32.addr);
    off  = int'((bus32.addr - BASE) >> 2) & 7;
    bits = bytes_to_bits(bus32.wmask);
    for (int d = 0; d < 2; d++) begin
      rise = h2 & ~h3 & wm[d];
      nirq = (m_edge[d] & m_imask[d]) != 32'h0;
      clr  = 32'h0;
      if (acc) begin
        rv = model_read(d, off);
        if (d == 0) q32.push_back({bus32.ren, rv});
        else        q8.push_back({bus32.ren, rv});
      end
      if (acc && bus32.wen) begin
        v = bus32.wdata & bits & wm[d];
        case (off)
          0: m_out[d] = (m_out[d] & ~bits) | v;
          1: m_out[d] = m_out[d] | v;
          2: m_out[d] = m_out[d] & ~v;
          3: m_out[d] = m_out[d] ^ v;
          4: m_dir[d] = (m_dir[d] & ~bits) | v;
          6: clr = v;
          7: if (IRQ_ON) m_imask[d] = (m_imask[d] & ~bits) | v;
          default: ;
        endcase
      end
      if (IRQ_ON) begin
        m_edge[d] = (m_edge[d] & ~clr) | rise;
        m_irq[d]  = nirq;
      end
    end
    h3 = h2; h2 = h1; h1 = pins;
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) reset_model();
      else        step_model();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      check("ready32", {31'h0, bus32.ready}, {31'h0, q32.size() != 0});
      if (q32.size() != 0) begin
        e = q32.pop_front();
        if (bus32.ready && e[32]) check("rdata32", bus32.rdata, e[31:0]);
      end
      check("ready8", {31'h0, bus8.ready}, {31'h0, q8.size() != 0});
      if (q8.size() != 0) begin
        e = q8.pop_front();
        if (bus8.ready && e[32]) check("rdata8", bus8.rdata, e[31:0]);
      end
      check("pins_out32", po32, m_out[0]);
      check("pins_oe32", oe32, m_dir[0]);
      check("pins_out8", {24'h0, po8}, m_out[1]);
      check("pins_oe8", {24'h0, oe8}, m_dir[1]);
      check("irq32", {31'h0, irq32}, {31'h0, m_irq[0]});
      check("irq8", {31'h0, irq8}, {31'h0, m_irq[1]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_bus(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    bus32.wen = w; bus32.ren = r; bus32.addr = a; bus32.wdata = d; bus32.wmask = m;
    bus8.wen  = w; bus8.ren  = r; bus8.addr  = a; bus8.wdata  = d; bus8.wmask  = m;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    set_bus(w, r, a, d, m);
    #1;
    check("active32", {31'h0, bus32.active}, {31'h0, in_window(a)});
    check("active8", {31'h0, bus8.active}, {31'h0, in_window(a)});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus32.wen = 1'b0; bus32.ren = 1'b0;
    bus8.wen  = 1'b0; bus8.ren  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_po32"}, po32, 32'h0);
    check({tag, "_oe32"}, oe32, 32'h0);
    check({tag, "_po8"}, {24'h0, po8}, 32'h0);
    check({tag, "_irq32"}, {31'h0, irq32}, 32'h0);
    check({tag, "_ready32"}, {31'h0, bus32.ready}, 32'h0);
    check({tag, "_ready8"}, {31'h0, bus8.ready}, 32'h0);
    check({tag, "_rdata32"}, bus32.rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    rst_n = 1'b0;
    pins  = 32'h0;
    set_bus(1'b0, 1'b0, BASE, 32'h0, 4'h0);
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values of every register, back-to-back reads.
    for (int o = 0; o < 8; o++) drive(1'b0, 1'b1, BASE + 32'(4 * o), 32'h0, 4'h0);
    idle(1);

    // Atomic bit manipulation.
    drive(1'b1, 1'b0, BASE + 32'd0,  32'h0000_00f0, 4'hf);
    drive(1'b1, 1'b0, BASE + 32'd4,  32'h0000_000f, 4'h1);
    drive(1'b1, 1'b0, BASE + 32'd8,  32'h0000_0030, 4'hf);
    drive(1'b1, 1'b0, BASE + 32'd12, 32'h8000_0000, 4'h8);
    idle(1);
    check("plan_out32", po32, 32'h8000_00cf);
    check("plan_out8", {24'h0, po8}, 32'h0000_00cf);
    drive(1'b1, 1'b0, BASE + 32'd4, 32'h0000_ff00, 4'h1);
    idle(1);
    check("masked_set", po32, 32'h8000_00cf);
    drive(1'b0, 1'b1, BASE + 32'd4, 32'h0, 4'h0);

    // Narrow instance masking and out-of-window strobes.
    drive(1'b1, 1'b0, BASE, 32'hffff_ffff, 4'hf);
    drive(1'b0, 1'b1, BASE, 32'h0, 4'h0);
    drive(1'b0, 1'b1, BASE + 32'd32, 32'h0, 4'h0);
    drive(1'b1, 1'b0, BASE + 32'd32, 32'h0, 4'hf);
    drive(1'b1, 1'b0, BASE - 32'd4, 32'h0, 4'hf);
    idle(2);
    check("outside_write", po32, 32'hffff_ffff);
    drive(1'b1, 1'b0, BASE + 32'd16, 32'h00a5_5a0f, 4'h5);
    drive(1'b0, 1'b1, BASE + 32'd16, 32'h0, 4'h0);

    // Input synchroniser, edge capture and interrupt.
    drive(1'b1, 1'b0, BASE + 32'd28, 32'h0000_0008, 4'hf);
    idle(4);
    pins = 32'h0000_0008;
    repeat (3) drive(1'b0, 1'b1, BASE + 32'd20, 32'h0, 4'h0);
    repeat (3) drive(1'b0, 1'b1, BASE + 32'd24, 32'h0, 4'h0);
    drive(1'b1, 1'b0, BASE + 32'd24, 32'h0000_0008, 4'h1);
    idle(3);

    // W1C in the very cycle a new edge on the same bit is captured.
    pins = 32'h0;
    idle(4);
    pins = 32'h0000_0008;
    idle(2);
    drive(1'b1, 1'b0, BASE + 32'd24, 32'h0000_0008, 4'hf);
    drive(1'b0, 1'b1, BASE + 32'd24, 32'h0, 4'h0);
    idle(2);

    // Simultaneous write and read.
    drive(1'b1, 1'b0, BASE, 32'h1, 4'hf);
    drive(1'b1, 1'b1, BASE, 32'h2, 4'hf);
    drive(1'b0, 1'b1, BASE, 32'h0, 4'h0);
    idle(1);
    check("wr_rd_out", po32, 32'h2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) pins = $urandom;
      k = int'($urandom_range(0, 9));
      a = BASE + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = a + 32'd32 * 32'($urandom_range(1, 3));
      if (k < 2)      idle(1);
      else if (k < 5) drive(1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)));
      else if (k < 9) drive(1'b0, 1'b1, a, 32'h0, 4'h0);
      else            drive(1'b1, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(2);

    // Reset asserted while a read response is on the bus.
    drive(1'b1, 1'b0, BASE, 32'h5a5a_5a5a, 4'hf);
    drive(1'b1, 1'b0, BASE + 32'd16, 32'hffff_ffff, 4'hf);
    set_bus(1'b1, 1'b1, BASE + 32'd4, 32'h0000_ffff, 4'hf);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    set_bus(1'b0, 1'b0, BASE, 32'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int o = 0; o < 8; o++) drive(1'b0, 1'b1, BASE + 32'(4 * o), 32'h0, 4'h0);
    idle(3);

    check("q32_drained", 32'(q32.size()), 32'h0);
    check("q8_drained", 32'(q8.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parallel_gpio.md
# parallel_gpio

Parametrised memory-mapped general-purpose I/O port on the CPU's simple load/store bus. Provides up to 32 bidirectional pins with per-pin direction, atomic set/clear/toggle of the output latch, a synchronised input view, and optional rising-edge interrupt capture. It replaces the fixed 32-bit write-only output port wherever software needs inputs, tristate control or race-free bit manipulation.

## Interface
- BASE_ADDR, 32'hf000, byte address of register 0; must be 32-byte aligned.
- WIDTH, 32, number of pins (1..32); register bits at or above WIDTH read 0 and ignore writes.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  32  bus byte address.
- wdata  in  32  write data.
- wmask  in  4  byte write enables; bit n qualifies wdata[8n+7:8n].
- wen  in  1  write strobe, single cycle.
- ren  in  1  read strobe, single cycle.
- rdata  out  32  registered read data, valid while ready is high.
- ready  out  1  transfer complete, one cycle after an accepted strobe.
- active  out  1  combinational address decode: addr[31:5] == BASE_ADDR[31:5].
- pins_in  in  WIDTH  asynchronous pad inputs.
- pins_out  out  WIDTH  output latch.
- pins_oe  out  WIDTH  output enable, 1 = drive.
- irq  out  1  level interrupt, registered.

## Operation
- Register word offsets (addr[4:2]): 0 OUT rw; 1 SET w (1 bits set OUT); 2 CLR w (1 bits clear OUT); 3 TGL w (1 bits invert OUT); 4 DIR rw (→ pins_oe); 5 IN ro; 6 EDGE rw1c; 7 IRQ_MASK rw. Offsets 1–3 read back OUT.
- All writes honour wmask per byte; for SET/CLR/TGL an unmasked byte means no change.
- IN = pins_in after a two-flop synchroniser; read regardless of DIR.
- EDGE[i] sets when synchronised pin i goes 0→1 (compare stage 2 with a third delayed flop). Writing 1 clears; in the same cycle a new edge on that bit wins (bit stays 1).
- irq <= |(EDGE & IRQ_MASK).
- Accepted strobe = (wen | ren) & active. Strobes with active low are ignored and produce no ready.
- wen and ren together: write performed; rdata returns the pre-write value.
- Reset: OUT, DIR, EDGE, IRQ_MASK, synchroniser flops, rdata, ready, irq all 0; pins_oe 0 so all pins are inputs. Reset asserted mid-transfer drops ready immediately; no partial write survives.

## Timing
- Write: register updates at the edge sampling wen; visible on pins_out/pins_oe the same edge.
- Read: rdata and ready registered at the edge sampling ren; ready high exactly one cycle per strobe; back-to-back strobes give back-to-back ready.
- Input: pin change appears in IN 2 edges after first sampling; EDGE sets on the 3rd edge; irq rises on the 4th.

## Configuration
- PARALLEL_GPIO_IRQ_EN defined: EDGE, IRQ_MASK, delay flop and irq logic present as above.
- Undefined: offsets 6 and 7 read 0 and ignore writes; irq tied 0; no edge-detect flops.

## Structure
- Package parallel_gpio_pkg: register offset localparams (REG_OUT…REG_IRQ_MASK), 3-bit reg_idx_t, helper function expanding wmask to a 32-bit bit mask.
- Sub-module gpio_sync: WIDTH-wide two-flop synchroniser with async active-low reset.

## Test plan
- Reset then read offsets 0–7 -> all rdata 0, pins_oe 0, irq 0; ready one cycle after each ren.
- Write OUT=0x0000_00F0 wmask 4'hF, SET 0x0F wmask 4'h1, CLR 0x30, TGL 0x8000_0000 wmask 4'h8 -> pins_out 0x8000_00CF; SET 0xFF00 wmask 4'h1 -> unchanged.
- WIDTH=8: write OUT 0xFFFF_FFFF -> read 0x0000_00FF; addr BASE_ADDR+32 strobe -> active 0, no ready.
- Drive pins_in[3] 0→1 with IRQ_MASK=0x8 -> IN bit 3 after 2 edges, EDGE=0x8 after 3, irq after 4; W1C 0x8 -> irq low next cycle.
- W1C EDGE bit 3 on the same cycle a new rising edge on pin 3 is detected -> EDGE bit 3 remains 1.
- Simultaneous wen+ren to OUT (old 0x1, new 0x2) -> rdata 0x1, subsequent read 0x2; assert rst_n low mid-sequence -> all outputs 0 asynchronously.
